seq_divider: RTL and testbench

- Iterative radix-2 restoring unsigned divider; inverse operation to the team's 16x16 multiplier datapath.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock.
- Sits beside the multiplier in the arithmetic unit, using valid/ready handshakes on both input and output.

---
 rtl/div_pkg.sv | 19 +
 rtl/div_step.sv | 25 ++
 rtl/seq_divider.sv | 111 +++++++++++
 tb/tb_seq_divider.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_t;

    // Iteration counter width: $clog2(WIDTH), never below one bit.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int unsigned DIV_CNT_W_DEFAULT = cnt_width(DIV_WIDTH_DEFAULT);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtract of D from the shifted
// partial remainder, producing the next remainder and one quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] i_r,
    input  logic             i_q_msb,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_r_next,
    output logic             o_q_bit
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    // The trial difference is WIDTH+1 bits so its MSB is a clean sign bit;
    // the surviving remainder is always below D, so it fits in WIDTH bits.
    assign w_shift  = {i_r, i_q_msb};
    assign w_trial  = w_shift - {1'b0, i_d};
    assign o_q_bit  = ~w_trial[WIDTH];
    assign o_r_next = o_q_bit ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring unsigned divider, one quotient bit per clock, with
// valid/ready handshakes on operands and result.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    div_state_t       r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_r;
    logic [CW-1:0]    r_cnt;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;

    logic [WIDTH-1:0] w_r_nxt;
    logic             w_q_bit;
    logic [WIDTH-1:0] w_q_nxt;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_r      (r_r),
        .i_q_msb  (r_q[WIDTH-1]),
        .i_d      (r_d),
        .o_r_next (w_r_nxt),
        .o_q_bit  (w_q_bit)
    );

    assign w_q_nxt = {r_q[WIDTH-2:0], w_q_bit};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_q         <= '0;
            r_d         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_quot      <= '0;
            r_rem       <= '0;
            r_dbz       <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_q        <= dividend;
                        r_d        <= divisor;
                        r_r        <= '0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        if (divisor == '0) begin
                            r_quot      <= '1;
                            r_rem       <= dividend;
                            r_dbz       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    r_r   <= w_r_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_quot      <= w_q_nxt;
                        r_rem       <= w_r_nxt;
                        r_dbz       <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign quotient    = r_quot;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: vector table, corner sequences and a
// random regression, all results checked through an expectation queue.
module tb_seq_divider;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;   // edges after the accepting edge until out_valid
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[12];
    int   nvec = 0;
    int   nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] q, input logic [W-1:0] r, input logic dbz);
        exp_t e;
        e.q = q; e.r = r; e.dbz = dbz;
        sb.push_back(e);
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int guard = 0;
        while (!in_ready && guard < 64) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input int exp_lat);
        int   lat = 0;
        exp_t e;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        if (!out_valid) begin
            chk("out_valid_timeout", 32'(out_valid), 32'd1);
            return;
        end
        if (exp_lat >= 0) chk("latency", 32'(lat), 32'(exp_lat));
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] q, input logic [W-1:0] r,
                          input logic dbz, input int lat);
        push_exp(q, r, dbz);
        start_op(a, b);
        wait_result(lat);
        handshake();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{16'd100,   16'd7,      16'd14,     16'd2,      1'b0, 16};
        tbl[1]  = '{16'hFFFF,  16'd1,      16'hFFFF,   16'd0,      1'b0, 16};
        tbl[2]  = '{16'hFFFF,  16'hFFFF,   16'd1,      16'd0,      1'b0, 16};
        tbl[3]  = '{16'd3,     16'd10,     16'd0,      16'd3,      1'b0, 16};
        tbl[4]  = '{16'd5,     16'd0,      16'hFFFF,   16'd5,      1'b1, 0};
        tbl[5]  = '{16'd9,     16'd3,      16'd3,      16'd0,      1'b0, 16};
        tbl[6]  = '{16'd0,     16'd5,      16'd0,      16'd0,      1'b0, 16};
        tbl[7]  = '{16'd0,     16'd0,      16'hFFFF,   16'd0,      1'b1, 0};
        tbl[8]  = '{16'h8000,  16'd3,      16'd10922,  16'd2,      1'b0, 16};
        tbl[9]  = '{16'hFFFE,  16'hFFFF,   16'd0,      16'hFFFE,   1'b0, 16};
        tbl[10] = '{16'd12345, 16'd12345,  16'd1,      16'd0,      1'b0, 16};
        tbl[11] = '{16'hFFFF,  16'h0100,   16'h00FF,   16'h00FF,   1'b0, 16};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);

        for (int i = 0; i < 12; i++)
            run_op(tbl[i].dvd, tbl[i].dvs, tbl[i].q, tbl[i].r, tbl[i].dbz, tbl[i].lat);

        // Backpressure: result held, stray operands ignored, in_ready low.
        push_exp(16'd30, 16'd10, 1'b0);
        start_op(16'd1000, 16'd33);
        wait_result(16);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            dividend = 16'd7;
            divisor  = 16'd1;
            @(posedge clk); #1;
            chk("stall_quotient", 32'(quotient), 32'd30);
            chk("stall_remainder", 32'(remainder), 32'd10);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        handshake();
        chk("release_in_ready", 32'(in_ready), 32'd1);
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_quotient_kept", 32'(quotient), 32'd30);
        repeat (3) @(posedge clk);
        #1 chk("idle_no_phantom_op", 32'(out_valid), 32'd0);

        // Reset in the middle of an operation at iteration count 8.
        start_op(16'd1000, 16'd33);
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_quotient", 32'(quotient), 32'd0);
        chk("midrst_remainder", 32'(remainder), 32'd0);
        chk("midrst_dbz", 32'(div_by_zero), 32'd0);
        run_op(16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 16);

        // Random regression against the arithmetic reference model.
        for (int i = 0; i < 2000; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom);
            b = (i % 4 == 0) ? W'($urandom_range(0, 15)) : W'($urandom);
            if (b == '0) push_exp('1, a, 1'b1);
            else push_exp(a / b, a % b, 1'b0);
            start_op(a, b);
            wait_result(-1);
            if (out_valid && b != '0) begin
                chk("rand_identity", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
                chk("rand_rem_lt_div", 32'(remainder < b), 32'd1);
            end
            handshake();
        end

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
